// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic [1:0]      i_div_op,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_div_data
);

    // state  | meaning
    // S_IDLE | waiting for i_start; special cases resolved here
    // S_CALC | one restoring quotient bit per cycle
    // S_DONE | o_valid high, o_div_data holds the new result
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] babs_q, babs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            is_signed, a_neg, b_neg, b_zero, ovf, early, special;
    logic [XLEN-1:0] a_abs, b_abs, spec_quo, spec_rem;
    logic [XLEN:0]   rem_sh, rem_nx;
    logic [XLEN-1:0] quo_nx, q_fix, r_fix;
    logic            ge;

    // Operand decode in IDLE
    always_comb begin
        is_signed = ~i_div_op[0];
        a_neg     = is_signed & i_operand_a[XLEN-1];
        b_neg     = is_signed & i_operand_b[XLEN-1];
        a_abs     = a_neg ? (~i_operand_a + 1'b1) : i_operand_a;
        b_abs     = b_neg ? (~i_operand_b + 1'b1) : i_operand_b;
        b_zero    = (i_operand_b == '0);
        ovf       = is_signed && (i_operand_a == MIN_NEG) && (i_operand_b == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = !b_zero && (a_abs < b_abs);
`else
        early     = 1'b0;
`endif
        special   = b_zero | ovf | early;
        spec_quo  = b_zero ? '1 : (ovf ? MIN_NEG : '0);
        spec_rem  = ovf ? '0 : i_operand_a;
    end

    // One restoring step plus the sign fix-up applied on the final step
    always_comb begin
        rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        ge     = (rem_sh >= {1'b0, babs_q});
        rem_nx = ge ? (rem_sh - {1'b0, babs_q}) : rem_sh;
        quo_nx = {quo_q[XLEN-2:0], ge};
        q_fix  = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
        r_fix  = neg_rem_q ? (~rem_nx[XLEN-1:0] + 1'b1) : rem_nx[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        babs_d    = babs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    is_rem_d = i_div_op[1];
                    if (special) begin
                        data_d  = i_div_op[1] ? spec_rem : spec_quo;
                        state_d = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_abs;
                        babs_d    = b_abs;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        count_d   = '0;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d   = rem_nx;
                quo_d   = quo_nx;
                count_d = count_q + 1'b1;
                if (count_q == CW'(XLEN-1)) begin
                    data_d  = is_rem_q ? r_fix : q_fix;
                    count_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            babs_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            babs_q    <= babs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            data_q    <= data_d;
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_valid    = (state_q == S_DONE);
    assign o_div_data = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  div_op;
    logic        busy;
    logic        valid;
    logic [31:0] div_data;

    int checks = 0;
    int passes = 0;

    div_unit #(.XLEN(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_operand_a (op_a),
        .i_operand_b (op_b),
        .i_div_op    (div_op),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_div_data  (div_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: RISC-V M-extension semantics using plain SV arithmetic
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op);
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Called one time unit after an edge while the DUT is idle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
        int cyc;
        logic busy_ok;
        logic [31:0] exp;
        exp    = ref_res(a, b, op);
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        div_op = op;
        @(posedge clk); #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        div_op = 2'($urandom_range(0, 3));
        cyc     = 1;
        busy_ok = busy;
        while (!valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            busy_ok &= busy;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(ref_lat(a, b, op)));
        chk({tag, " data"}, div_data, exp);
        chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk); #1;
        chk({tag, " idle"}, {30'd0, busy, valid}, 32'd0);
        chk({tag, " hold"}, div_data, exp);
    endtask

    initial begin
        int cyc;
        logic saw_valid;
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        div_op = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy/valid", {30'd0, busy, valid}, 32'd0);
        chk("reset data", div_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("DIV 100/7", 32'd100, 32'd7, 2'b00);
        run_op("REM -7/2", 32'hFFFF_FFF9, 32'd2, 2'b10);
        run_op("DIV -7/2", 32'hFFFF_FFF9, 32'd2, 2'b00);
        run_op("DIVU x/0", 32'h1234_5678, 32'd0, 2'b01);
        run_op("REMU x/0", 32'h1234_5678, 32'd0, 2'b11);
        run_op("DIV ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
        run_op("REM ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10);
        run_op("DIVU ovf-ops", 32'h8000_0000, 32'hFFFF_FFFF, 2'b01);
        run_op("DIVU 5/9", 32'd5, 32'd9, 2'b01);
        run_op("REMU 5/9", 32'd5, 32'd9, 2'b11);
        run_op("REM -5/9", 32'hFFFF_FFFB, 32'd9, 2'b10);
        run_op("DIV 0/0", 32'd0, 32'd0, 2'b00);

        // Start ignored while busy
        start = 1'b1; op_a = 32'd1000; op_b = 32'd3; div_op = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!valid && cyc < 40) begin
            if (cyc == 10) begin
                start = 1'b1; op_a = 32'd77; op_b = 32'd5; div_op = 2'b00;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("ignored-start latency", 32'(cyc), 32'd33);
        chk("ignored-start data", div_data, 32'd333);
        @(posedge clk); #1;

        // Reset mid-operation discards the op
        start = 1'b1; op_a = 32'd1000; op_b = 32'd3; div_op = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset busy/valid", {30'd0, busy, valid}, 32'd0);
        chk("midreset data", div_data, 32'd0);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw_valid |= valid;
        end
        chk("midreset no valid", {31'd0, saw_valid}, 32'd0);

        // Randomized ops, back-to-back
        for (int n = 0; n < 40; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                4: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 60)); end
                5: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", n, rop), ra, rb, rop);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
